counter_bank_snapshot: RTL

- Parametrised successor to the single enabled register/counter block: NR_CHANNELS independent WIDTH-bit event counters, each with its own enable and clear, a shared programmable limit, and a selectable wrap or saturate mode.
- An atomic snapshot engine captures all counters in one cycle and streams them out one channel per beat over a valid/ready port.
- Sits between event sources and a status or readout interface.

---
 rtl/counter_bank_snapshot_if.sv | 16 +
 rtl/counter_bank_snapshot.sv | 116 +++++++++++
 2 files changed

// File: rtl/counter_bank_snapshot_if.sv
// Snapshot readout channel: one counter value per beat, valid/ready handshake.
// The producer holds channel and data stable while ready is low.
interface counter_bank_snapshot_if #(
    parameter int WIDTH       = 8,
    parameter int NR_CHANNELS = 4
);
    localparam int CH_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1;

    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [CH_W-1:0] rd_channel_o;
    logic [WIDTH-1:0] rd_data_o;

    modport master (output rd_valid_o, output rd_channel_o, output rd_data_o, input rd_ready_i);
    modport slave  (input rd_valid_o, input rd_channel_o, input rd_data_o, output rd_ready_i);
endinterface

// File: rtl/counter_bank_snapshot.sv
// Bank of wrap/saturate event counters with an atomic snapshot streamed out one channel per beat.
// First beat 1 cycle after snap_i; beats hold while rd_ready_i is low; snap_i while busy is dropped.
module counter_bank_snapshot #(
    parameter int WIDTH       = 8,
    parameter int NR_CHANNELS = 4,
    parameter int SATURATE    = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NR_CHANNELS-1:0] enable_i,
    input  logic [NR_CHANNELS-1:0] clear_i,
    input  logic [WIDTH-1:0]       limit_i,
    input  logic                   snap_i,
    counter_bank_snapshot_if.master rd,
    output logic [NR_CHANNELS-1:0] wrap_o,
    output logic                   busy_o,
    output logic                   snap_drop_o
);
    localparam int CH_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NR_CHANNELS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [WIDTH-1:0]       cnt_q    [NR_CHANNELS];
    logic [WIDTH-1:0]       cnt_d    [NR_CHANNELS];
    logic [WIDTH-1:0]       shadow_q [NR_CHANNELS];
    logic [NR_CHANNELS-1:0] wrap_q, wrap_d;

    state_t           state_q;
    logic             busy_q, valid_q, drop_q;
    logic [CH_W-1:0]  ch_q, ch_nxt;
    logic [WIDTH-1:0] data_q;

    assign ch_nxt = ch_q + CH_W'(1);

    always_comb begin
        for (int i = 0; i < NR_CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            wrap_d[i] = 1'b0;
            if (clear_i[i]) begin
                cnt_d[i] = '0;
            end else if (enable_i[i]) begin
                if (cnt_q[i] < limit_i) begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    // Saturating counters flag only the increment that lands on the limit.
                    if (SATURATE != 0 && cnt_d[i] == limit_i) wrap_d[i] = 1'b1;
                end else if (SATURATE == 0) begin
                    cnt_d[i]  = '0;
                    wrap_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = limit_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_CHANNELS; i++) cnt_q[i] <= '0;
            wrap_q <= '0;
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) cnt_q[i] <= cnt_d[i];
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_CHANNELS; i++) shadow_q[i] <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (snap_i) begin
                        // Capture the values the counters take on this same edge.
                        for (int i = 0; i < NR_CHANNELS; i++) shadow_q[i] <= cnt_d[i];
                        state_q <= STREAM;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        ch_q    <= '0;
                        data_q  <= cnt_d[0];
                    end
                end
                STREAM: begin
                    drop_q <= snap_i;
                    if (rd.rd_ready_i) begin
                        if (ch_q == LAST_CH) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            ch_q    <= '0;
                            data_q  <= '0;
                        end else begin
                            ch_q   <= ch_nxt;
                            data_q <= shadow_q[ch_nxt];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd.rd_valid_o   = valid_q;
    assign rd.rd_channel_o = ch_q;
    assign rd.rd_data_o    = data_q;
    assign wrap_o          = wrap_q;
    assign busy_o          = busy_q;
    assign snap_drop_o     = drop_q;
endmodule
